// File: rtl/arrow_judge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arrow_judge : lane hit judgement, score/combo/miss counters, game flow     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module arrow_judge #(
  parameter int FRAMES      = 200,
  parameter int PERF_LO     = 150,
  parameter int PERF_HI     = 185,
  parameter int GOOD_LO     = 130,
  parameter int GOOD_HI     = 199,
  parameter int HOLD_CYCLES = 12500000,
  parameter int MISS_LIMIT  = 10
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        enter,
  input  logic [3:0]  btn,
  input  logic [3:0]  visible,
  input  logic [7:0]  d_fc,
  input  logic [7:0]  u_fc,
  input  logic [7:0]  l_fc,
  input  logic [7:0]  r_fc,
  output logic [2:0]  decode,
  output logic [13:0] score,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [3:0]  misses,
  output logic [1:0]  state,
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  localparam int              c_HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD   = c_HOLD_W'(HOLD_CYCLES);
  localparam logic [7:0]      c_FRAMES     = 8'(FRAMES);
  localparam logic [7:0]      c_PERF_LO    = 8'(PERF_LO);
  localparam logic [7:0]      c_PERF_HI    = 8'(PERF_HI);
  localparam logic [7:0]      c_GOOD_LO    = 8'(GOOD_LO);
  localparam logic [7:0]      c_GOOD_HI    = 8'(GOOD_HI);
  localparam logic [3:0]      c_MISS_LIMIT = 4'(MISS_LIMIT);
  localparam logic [1:0]      c_PERFECT    = 2'd1;
  localparam logic [1:0]      c_GOOD       = 2'd2;
  localparam logic [1:0]      c_MISS       = 2'd3;

  state_t              r_state;
  logic                r_enter_s1, r_enter_s2, r_enter_prev, r_enter_edge;
  logic [3:0]          r_btn_s1, r_btn_s2, r_btn_prev, r_btn_edge;
  logic [3:0]          r_vis, r_vis_q, r_hit_done;
  logic [1:0]          r_slot [4];
  logic [c_HOLD_W-1:0] r_hold;

  logic [7:0] w_fc [4];
  logic [1:0] w_code [4];
  logic [3:0] w_rise, w_fall, w_ev, w_drain;
  logic [1:0] w_dcode;
  logic [7:0] w_combo_inc;
  logic       w_play, w_go_over, w_flush, w_drop;

  assign w_fc[0]     = d_fc;
  assign w_fc[1]     = u_fc;
  assign w_fc[2]     = l_fc;
  assign w_fc[3]     = r_fc;
  assign w_play      = (r_state == S_PLAY);
  assign w_rise      = r_vis & ~r_vis_q;
  assign w_fall      = r_vis_q & ~r_vis;
  assign w_combo_inc = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;
  assign state       = r_state;

  // A press in the same cycle as a visibility fall still counts as visible.
  always_comb begin
    w_ev = '0;
    for (int i = 0; i < 4; i++) begin
      w_code[i] = c_MISS;
      if (w_play) begin
        if (r_btn_edge[i]) begin
          if (!(r_vis[i] | w_fall[i])) begin
            w_ev[i] = 1'b1;
          end else if (!(r_hit_done[i] & ~w_rise[i])) begin
            w_ev[i] = 1'b1;
            if (w_fc[i] >= c_PERF_LO && w_fc[i] <= c_PERF_HI && w_fc[i] < c_FRAMES)
              w_code[i] = c_PERFECT;
            else if (w_fc[i] >= c_GOOD_LO && w_fc[i] <= c_GOOD_HI && w_fc[i] < c_FRAMES)
              w_code[i] = c_GOOD;
          end
        end else if (w_fall[i] && !r_hit_done[i]) begin
          w_ev[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_drain = 4'b0000;
    w_dcode = 2'd0;
    if (w_play) begin
      if (r_slot[0] != 2'd0) begin
        w_drain = 4'b0001; w_dcode = r_slot[0];
      end else if (r_slot[1] != 2'd0) begin
        w_drain = 4'b0010; w_dcode = r_slot[1];
      end else if (r_slot[2] != 2'd0) begin
        w_drain = 4'b0100; w_dcode = r_slot[2];
      end else if (r_slot[3] != 2'd0) begin
        w_drain = 4'b1000; w_dcode = r_slot[3];
      end
    end
  end

  assign w_go_over = (w_drain != 4'b0000) && (w_dcode == c_MISS) &&
                     ((misses + 4'd1) == c_MISS_LIMIT);
  assign w_flush   = !w_play || w_go_over;
  assign w_drop    = (w_ev[0] && r_slot[0] != 2'd0) || (w_ev[1] && r_slot[1] != 2'd0) ||
                     (w_ev[2] && r_slot[2] != 2'd0) || (w_ev[3] && r_slot[3] != 2'd0);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_enter_s1   <= 1'b0;
      r_enter_s2   <= 1'b0;
      r_enter_prev <= 1'b0;
      r_enter_edge <= 1'b0;
      r_btn_s1     <= '0;
      r_btn_s2     <= '0;
      r_btn_prev   <= '0;
      r_btn_edge   <= '0;
      r_vis        <= '0;
      r_vis_q      <= '0;
      r_hit_done   <= '0;
      for (int i = 0; i < 4; i++) r_slot[i] <= 2'd0;
    end else begin
      r_enter_s1   <= enter;
      r_enter_s2   <= r_enter_s1;
      r_enter_prev <= r_enter_s2;
      r_enter_edge <= r_enter_s2 & ~r_enter_prev;
      r_btn_s1     <= btn;
      r_btn_s2     <= r_btn_s1;
      r_btn_prev   <= r_btn_s2;
      r_btn_edge   <= r_btn_s2 & ~r_btn_prev;
      r_vis        <= visible;
      r_vis_q      <= r_vis;
      for (int i = 0; i < 4; i++) begin
        if (r_state == S_IDLE && r_enter_edge)
          r_hit_done[i] <= 1'b0;
        else if (w_play && r_btn_edge[i] && (r_vis[i] | w_fall[i]))
          r_hit_done[i] <= 1'b1;
        else if (w_rise[i])
          r_hit_done[i] <= 1'b0;

        // A slot being drained this cycle still counts as full.
        if (w_flush)
          r_slot[i] <= 2'd0;
        else if (w_ev[i] && r_slot[i] == 2'd0)
          r_slot[i] <= w_code[i];
        else if (w_drain[i])
          r_slot[i] <= 2'd0;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      decode    <= 3'd0;
      score     <= 14'd0;
      combo     <= 8'd0;
      max_combo <= 8'd0;
      misses    <= 4'd0;
      overrun   <= 1'b0;
    end else begin
      if (w_drop) overrun <= 1'b1;
      if (r_hold != '0) begin
        r_hold <= r_hold - c_HOLD_W'(1);
        if (r_hold == c_HOLD_W'(1)) decode <= 3'd0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_enter_edge) begin
            r_state   <= S_PLAY;
            score     <= 14'd0;
            combo     <= 8'd0;
            max_combo <= 8'd0;
            misses    <= 4'd0;
            overrun   <= 1'b0;
          end
        end
        S_PLAY: begin
          if (w_drain != 4'b0000) begin
            decode <= {1'b0, w_dcode};
            r_hold <= c_HOLD;
            if (w_dcode == c_MISS) begin
              combo  <= 8'd0;
              misses <= misses + 4'd1;
            end else begin
              if (w_dcode == c_PERFECT)
                score <= (score >= 14'd9997) ? 14'd9999 : score + 14'd3;
              else
                score <= (score >= 14'd9999) ? 14'd9999 : score + 14'd1;
              combo <= w_combo_inc;
              if (w_combo_inc > max_combo) max_combo <= w_combo_inc;
            end
          end
          if (w_go_over) begin
            r_state <= S_OVER;
            decode  <= 3'd4;
            r_hold  <= '0;
          end else if (r_enter_edge) begin
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          if (r_enter_edge) begin
            r_state <= S_IDLE;
            decode  <= 3'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
